// File: rtl/filter_output_arbiter.sv
// Round-robin read arbiter over the per-filter pair buffers with credit flow control toward the force pipeline.
// Define FILTER_ARB_STATS_EN to add per-filter grant counters and a credit-stall counter.
module filter_output_arbiter #(
  parameter int unsigned NUM_FILTERS = 7,
  parameter int unsigned NUM_CREDITS = 8,
  localparam int unsigned CW = $clog2(NUM_CREDITS + 1),
  localparam int unsigned PW = (NUM_FILTERS > 1) ? $clog2(NUM_FILTERS) : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_enable,
  input  logic [NUM_FILTERS-1:0] i_filter_buffer_empty,
  input  logic [NUM_FILTERS-1:0] i_filter_buffer_almost_empty,
  input  logic                   i_credit_return,
  output logic [NUM_FILTERS-1:0] o_filter_buffer_rd_en,
  output logic [NUM_FILTERS-1:0] o_filter_output_arb_result,
  output logic                   o_arb_valid,
  output logic [CW-1:0]          o_credit_cnt,
  output logic                   o_credit_err
`ifdef FILTER_ARB_STATS_EN
  ,
  output logic [31:0]            o_grant_cnt [NUM_FILTERS],
  output logic [31:0]            o_stall_cnt
`endif
);

  logic [PW-1:0]          ptr_q, ptr_d;
  logic [NUM_FILTERS-1:0] last_grant_q;
  logic [NUM_FILTERS-1:0] arb_result_q;
  logic                   arb_valid_q;
  logic [CW-1:0]          credit_cnt_q, credit_cnt_d;
  logic                   credit_err_q, credit_err_d;

  logic [NUM_FILTERS-1:0] eligible;
  logic [NUM_FILTERS-1:0] rd_en;
  logic [PW-1:0]          win_idx;
  logic                   found;
  logic                   grant;

  // A buffer just read while holding one entry still looks non-empty this cycle; skip it.
  always_comb begin
    eligible = ~i_filter_buffer_empty & ~(last_grant_q & i_filter_buffer_almost_empty);
    found    = 1'b0;
    win_idx  = '0;
    for (int unsigned k = 0; k < NUM_FILTERS; k++) begin
      if (!found && eligible[PW'((32'(ptr_q) + k) % NUM_FILTERS)]) begin
        found   = 1'b1;
        win_idx = PW'((32'(ptr_q) + k) % NUM_FILTERS);
      end
    end
    grant = rst_n & i_enable & (credit_cnt_q != '0) & found;
    rd_en = grant ? (NUM_FILTERS'(1) << win_idx) : '0;
  end

  // Pointer advance and credit accounting; a return while full saturates and flags an error.
  always_comb begin
    ptr_d        = ptr_q;
    credit_cnt_d = credit_cnt_q;
    credit_err_d = credit_err_q;
    if (grant) begin
      ptr_d = (win_idx == PW'(NUM_FILTERS - 1)) ? '0 : win_idx + PW'(1);
    end
    if (grant && !i_credit_return) begin
      credit_cnt_d = credit_cnt_q - CW'(1);
    end else if (!grant && i_credit_return) begin
      if (credit_cnt_q == CW'(NUM_CREDITS)) begin
        credit_err_d = 1'b1;
      end else begin
        credit_cnt_d = credit_cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q        <= '0;
      last_grant_q <= '0;
      arb_result_q <= '0;
      arb_valid_q  <= 1'b0;
      credit_cnt_q <= CW'(NUM_CREDITS);
      credit_err_q <= 1'b0;
    end else begin
      ptr_q        <= ptr_d;
      last_grant_q <= rd_en;
      arb_result_q <= rd_en;
      arb_valid_q  <= |rd_en;
      credit_cnt_q <= credit_cnt_d;
      credit_err_q <= credit_err_d;
    end
  end

  assign o_filter_buffer_rd_en      = rd_en;
  assign o_filter_output_arb_result = arb_result_q;
  assign o_arb_valid                = arb_valid_q;
  assign o_credit_cnt               = credit_cnt_q;
  assign o_credit_err               = credit_err_q;

`ifdef FILTER_ARB_STATS_EN
  logic [31:0] grant_cnt_q [NUM_FILTERS];
  logic [31:0] stall_cnt_q;

  // Stall counts cycles where work exists but downstream has no room.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned f = 0; f < NUM_FILTERS; f++) grant_cnt_q[f] <= '0;
      stall_cnt_q <= '0;
    end else begin
      for (int unsigned f = 0; f < NUM_FILTERS; f++) begin
        if (rd_en[f]) grant_cnt_q[f] <= grant_cnt_q[f] + 32'd1;
      end
      if (i_enable && (|eligible) && (credit_cnt_q == '0)) stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign o_grant_cnt = grant_cnt_q;
  assign o_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_filter_output_arbiter.sv
// Self-checking bench for filter_output_arbiter (4 filters, 4 credits) against an index-level reference model.
module tb_filter_output_arbiter;
  localparam int NF = 4;
  localparam int NC = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b0;
  logic [NF-1:0] empty = '1;
  logic [NF-1:0] aempty = '0;
  logic          ret = 1'b0;
  logic [NF-1:0] rd_en, arb_res;
  logic          arb_valid;
  logic [2:0]    credit_cnt;
  logic          credit_err;
`ifdef FILTER_ARB_STATS_EN
  logic [31:0]   grant_cnt [NF];
  logic [31:0]   stall_cnt;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model state: pointer, last granted index (-1 none), credits, sticky error, pending result.
  int m_ptr, m_last, m_cnt, m_res;
  bit m_err;

  filter_output_arbiter #(.NUM_FILTERS(NF), .NUM_CREDITS(NC)) dut (
    .clk                          (clk),
    .rst_n                        (rst_n),
    .i_enable                     (en),
    .i_filter_buffer_empty        (empty),
    .i_filter_buffer_almost_empty (aempty),
    .i_credit_return              (ret),
    .o_filter_buffer_rd_en        (rd_en),
    .o_filter_output_arb_result   (arb_res),
    .o_arb_valid                  (arb_valid),
    .o_credit_cnt                 (credit_cnt),
    .o_credit_err                 (credit_err)
`ifdef FILTER_ARB_STATS_EN
    ,
    .o_grant_cnt                  (grant_cnt),
    .o_stall_cnt                  (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [NF-1:0] onehot(input int i);
    logic [NF-1:0] v;
    v = '0;
    if (i >= 0) v[i] = 1'b1;
    return v;
  endfunction

  function automatic int model_winner(input logic [NF-1:0] emp, input logic [NF-1:0] aemp, input logic e);
    int idx;
    if (!e || m_cnt == 0) return -1;
    for (int k = 0; k < NF; k++) begin
      idx = (m_ptr + k) % NF;
      if (!emp[idx] && !(idx == m_last && aemp[idx])) return idx;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_ptr = 0; m_last = -1; m_cnt = NC; m_res = -1; m_err = 1'b0;
  endtask

  task automatic model_update(input int w, input logic r);
    m_res  = w;
    m_last = w;
    if (w >= 0) m_ptr = (w + 1) % NF;
    if (w >= 0 && !r) m_cnt = m_cnt - 1;
    else if (w < 0 && r) begin
      if (m_cnt == NC) m_err = 1'b1;
      else m_cnt = m_cnt + 1;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    en = 1'b1; empty = '0; aempty = '0; ret = 1'b0;
    @(negedge clk); #1;
    checks++; if (rd_en !== '0) begin errors++; $display("FAIL reset_rd_en got %b exp 0000", rd_en); end
    checks++; if (arb_res !== '0) begin errors++; $display("FAIL reset_arb_result got %b exp 0000", arb_res); end
    checks++; if (arb_valid !== 1'b0) begin errors++; $display("FAIL reset_arb_valid got %b exp 0", arb_valid); end
    checks++; if (credit_cnt !== 3'(NC)) begin errors++; $display("FAIL reset_credit_cnt got %0d exp %0d", credit_cnt, NC); end
    checks++; if (credit_err !== 1'b0) begin errors++; $display("FAIL reset_credit_err got %b exp 0", credit_err); end
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_rotation();
    logic [NF-1:0] seq [5];
    logic [NF-1:0] prev;
    int w;
    seq[0] = 4'b0001; seq[1] = 4'b0010; seq[2] = 4'b0100; seq[3] = 4'b1000; seq[4] = 4'b0001;
    do_reset();
    prev = '0;
    for (int c = 0; c < 5; c++) begin
      en = 1'b1; empty = '0; aempty = '0; ret = 1'b1;
      #1;
      w = model_winner(empty, aempty, en);
      checks++; if (rd_en !== seq[c]) begin errors++; $display("FAIL rot_rd_en cyc %0d got %b exp %b", c, rd_en, seq[c]); end
      checks++; if (arb_res !== prev) begin errors++; $display("FAIL rot_arb_result cyc %0d got %b exp %b", c, arb_res, prev); end
      if (c > 0) begin
        checks++; if (arb_valid !== 1'b1) begin errors++; $display("FAIL rot_arb_valid cyc %0d got %b exp 1", c, arb_valid); end
      end
      checks++; if (credit_cnt !== 3'(NC)) begin errors++; $display("FAIL rot_credit_cnt cyc %0d got %0d exp %0d", c, credit_cnt, NC); end
      prev = seq[c];
      @(posedge clk); model_update(w, ret);
      @(negedge clk);
    end
  endtask

  task automatic test_almost_empty();
    logic [NF-1:0] prev;
    int grants, w;
    do_reset();
    prev = '0; grants = 0;
    for (int c = 0; c < 12; c++) begin
      en = 1'b1; empty = 4'b1011; aempty = 4'b0100; ret = (m_cnt < NC);
      #1;
      w = model_winner(empty, aempty, en);
      checks++; if (rd_en !== onehot(w)) begin errors++; $display("FAIL ae_rd_en cyc %0d got %b exp %b", c, rd_en, onehot(w)); end
      checks++; if ((rd_en & prev) !== '0) begin errors++; $display("FAIL ae_consecutive cyc %0d got %b after %b exp no repeat", c, rd_en, prev); end
      if (rd_en == 4'b0100) grants++;
      prev = rd_en;
      @(posedge clk); model_update(w, ret);
      @(negedge clk);
    end
    checks++; if (grants != 6) begin errors++; $display("FAIL ae_grant_count got %0d exp 6", grants); end
  endtask

  task automatic test_credits();
    int grants, w;
    do_reset();
    grants = 0;
    for (int c = 0; c < 6; c++) begin
      en = 1'b1; empty = '0; aempty = '0; ret = 1'b0;
      #1;
      w = model_winner(empty, aempty, en);
      checks++; if (rd_en !== onehot(w)) begin errors++; $display("FAIL cr_rd_en cyc %0d got %b exp %b", c, rd_en, onehot(w)); end
      if (rd_en != '0) grants++;
      @(posedge clk); model_update(w, ret);
      @(negedge clk);
    end
    #1;
    checks++; if (grants != NC) begin errors++; $display("FAIL cr_grant_count got %0d exp %0d", grants, NC); end
    checks++; if (credit_cnt !== 3'd0) begin errors++; $display("FAIL cr_cnt_empty got %0d exp 0", credit_cnt); end
    ret = 1'b1;
    #1;
    checks++; if (rd_en !== '0) begin errors++; $display("FAIL cr_no_grant_on_return got %b exp 0000", rd_en); end
    @(posedge clk); model_update(-1, 1'b1);
    @(negedge clk); ret = 1'b0; #1;
    checks++; if (credit_cnt !== 3'd1) begin errors++; $display("FAIL cr_cnt_one got %0d exp 1", credit_cnt); end
    w = model_winner(empty, aempty, en);
    checks++; if (rd_en !== onehot(w) || w < 0) begin errors++; $display("FAIL cr_regrant got %b exp %b", rd_en, onehot(w)); end
    @(posedge clk); model_update(w, 1'b0);
    @(negedge clk); #1;
    checks++; if (credit_cnt !== 3'd0) begin errors++; $display("FAIL cr_cnt_back_zero got %0d exp 0", credit_cnt); end
  endtask

  task automatic test_credit_err();
    do_reset();
    en = 1'b1; empty = '1; aempty = '0; ret = 1'b1;
    @(posedge clk); model_update(-1, 1'b1);
    @(negedge clk); ret = 1'b0;
    for (int c = 0; c < 4; c++) begin
      #1;
      checks++; if (credit_cnt !== 3'(NC)) begin errors++; $display("FAIL err_cnt_sat cyc %0d got %0d exp %0d", c, credit_cnt, NC); end
      checks++; if (credit_err !== 1'b1) begin errors++; $display("FAIL err_sticky cyc %0d got %b exp 1", c, credit_err); end
      @(negedge clk);
    end
    do_reset(); #1;
    checks++; if (credit_err !== 1'b0) begin errors++; $display("FAIL err_cleared got %b exp 0", credit_err); end
  endtask

  task automatic test_enable_ptr();
    do_reset();
    en = 1'b1; empty = 4'b1101; aempty = '0; ret = 1'b0; #1;
    checks++; if (rd_en !== 4'b0010) begin errors++; $display("FAIL en_setup got %b exp 0010", rd_en); end
    @(posedge clk); model_update(1, 1'b0);
    @(negedge clk); empty = 4'b0101; #1;
    checks++; if (rd_en !== 4'b1000) begin errors++; $display("FAIL en_first_3 got %b exp 1000", rd_en); end
    @(posedge clk); model_update(3, 1'b0);
    @(negedge clk); en = 1'b0; #1;
    checks++; if (rd_en !== 4'b0000) begin errors++; $display("FAIL en_off_rd_en got %b exp 0000", rd_en); end
    checks++; if (arb_res !== 4'b1000 || arb_valid !== 1'b1) begin errors++; $display("FAIL en_off_inflight got %b/%b exp 1000/1", arb_res, arb_valid); end
    @(posedge clk); model_update(-1, 1'b0);
    @(negedge clk); #1;
    checks++; if (arb_valid !== 1'b0 || credit_cnt !== 3'd2) begin errors++; $display("FAIL en_off_hold got valid %b cnt %0d exp 0 2", arb_valid, credit_cnt); end
    en = 1'b1; #1;
    checks++; if (rd_en !== 4'b0010) begin errors++; $display("FAIL en_resume_1 got %b exp 0010", rd_en); end
    @(posedge clk); model_update(1, 1'b0);
    @(negedge clk);
  endtask

  task automatic test_async_reset();
    int w;
    do_reset();
    for (int c = 0; c < 3; c++) begin
      en = 1'b1; empty = '0; aempty = '0; ret = 1'b0; #1;
      w = model_winner(empty, aempty, en);
      @(posedge clk); model_update(w, ret);
      @(negedge clk);
    end
    #2 rst_n = 1'b0; #1;
    checks++; if (rd_en !== '0) begin errors++; $display("FAIL arst_rd_en got %b exp 0000", rd_en); end
    checks++; if (arb_res !== '0 || arb_valid !== 1'b0) begin errors++; $display("FAIL arst_result got %b/%b exp 0000/0", arb_res, arb_valid); end
    checks++; if (credit_cnt !== 3'(NC)) begin errors++; $display("FAIL arst_cnt got %0d exp %0d", credit_cnt, NC); end
    @(negedge clk); rst_n = 1'b1; model_reset(); #1;
    checks++; if (rd_en !== 4'b0001) begin errors++; $display("FAIL arst_first_grant got %b exp 0001", rd_en); end
    @(posedge clk); model_update(0, 1'b0);
    @(negedge clk);
  endtask

  task automatic test_random();
    int w;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      en     = ($urandom_range(9) != 0);
      empty  = NF'($urandom);
      aempty = NF'($urandom);
      ret    = $urandom_range(1) != 0;
      #1;
      w = model_winner(empty, aempty, en);
      checks++; if (rd_en !== onehot(w)) begin errors++; $display("FAIL rnd_rd_en cyc %0d got %b exp %b", c, rd_en, onehot(w)); end
      checks++; if (arb_res !== onehot(m_res)) begin errors++; $display("FAIL rnd_arb_result cyc %0d got %b exp %b", c, arb_res, onehot(m_res)); end
      checks++; if (arb_valid !== (m_res >= 0)) begin errors++; $display("FAIL rnd_arb_valid cyc %0d got %b exp %b", c, arb_valid, m_res >= 0); end
      checks++; if (credit_cnt !== 3'(m_cnt)) begin errors++; $display("FAIL rnd_credit_cnt cyc %0d got %0d exp %0d", c, credit_cnt, m_cnt); end
      checks++; if (credit_err !== m_err) begin errors++; $display("FAIL rnd_credit_err cyc %0d got %b exp %b", c, credit_err, m_err); end
      @(posedge clk); model_update(w, ret);
      @(negedge clk);
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_rotation();
    test_almost_empty();
    test_credits();
    test_credit_err();
    test_enable_ptr();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
